alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Front-end sequencer and result collector for the pipelined ALU.
- Holds a small loadable program buffer of {op, a, b} instructions and issues them to the ALU pipeline over a valid/ready handshake.
- Bounds the number of in-flight operations with a credit counter.
- Collects returning results, in order, into a result buffer that can be read back.
- Sits between the host or bench load logic and the ALU pipeline input, and also terminates the pipeline's result output.

Parameters:
- DEPTH, 8: number of program and result entries; must be a power of two, at least 2.
- AW, 3: address width, equal to log2(DEPTH).
- OP_W, 3: ALU opcode width.
- DATA_W, 8: operand and result width.
- MAX_INFLIGHT, 4: maximum number of issued-but-unreturned operations (1..15).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  writes load_data into the program buffer at load_addr.
- load_addr  in  AW  program buffer write address.
- load_data  in  OP_W+2*DATA_W  instruction, packed as {op, a, b} with op in the MSBs.
- start  in  1  begins a run of len instructions.
- len  in  AW+1  number of instructions to run (0..DEPTH); sampled on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  sticky error flag; cleared by an accepted start.
- iss_valid  out  1  an instruction is offered to the ALU.
- iss_ready  in  1  the ALU accepts the offered instruction.
- iss_op  out  OP_W  offered opcode.
- iss_a  out  DATA_W  offered operand a.
- iss_b  out  DATA_W  offered operand b.
- res_valid  in  1  the ALU presents a result.
- res_data  in  DATA_W  result value.
- rd_addr  in  AW  result buffer read address.
- rd_data  out  DATA_W  result buffer data; combinational read.

Behaviour:
- Reset (reset=0): all outputs go to 0. FSM goes to IDLE. All pointers and counters are cleared. Program and result buffers are cleared to 0.
- FSM states are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - load_en writes the program buffer in the same cycle's edge.
  - start loads N=len, clears issue pointer, result pointer, inflight and err, and sets busy. Next state is ISSUE.
  - If len=0, next state is DONE instead.
  - If len>DEPTH, err is set and next state is DONE.
- ISSUE:
  - iss_valid=1 whenever inflight<MAX_INFLIGHT.
  - The iss_* fields come from prog[issue_ptr]. They are registered and held stable while iss_valid=1 and iss_ready=0.
  - A transfer occurs when iss_valid and iss_ready are both high. On transfer, issue_ptr and inflight each increment.
  - After the Nth transfer, iss_valid drops the next cycle and the FSM enters DRAIN.
- Credit rules:
  - A transfer and a res_valid in the same cycle leave inflight unchanged.
  - A transfer at inflight=MAX_INFLIGHT is impossible, because iss_valid is low.
- Results:
  - A res_valid with inflight>0 writes res_data to res_buf[res_ptr], then increments res_ptr and decrements inflight.
  - A res_valid with inflight=0, or outside ISSUE/DRAIN, is dropped and sets err.
  - Writes are accepted in both ISSUE and DRAIN.
- DRAIN: when res_ptr reaches N, the next state is DONE.
- DONE: done=1 for exactly one cycle. busy drops in that same cycle. Next state is IDLE.
- Ignored inputs:
  - load_en is ignored when not in IDLE.
  - start is ignored when not in IDLE.
- Pointers do not wrap within a run, since N≤DEPTH. N=DEPTH fills both buffers exactly.
- Reset asserted mid-run aborts the run immediately. No done pulse is produced. The state after release is identical to power-up.
- rd_data=res_buf[rd_addr] at all times. Reads during a run return partial results.
- Minimum run latency, with iss_ready=1 and a 1-cycle ALU: N+3 cycles from start to done.

Test Plan:
- Load 3 instructions, for example {ADD,5,3}, {SUB,9,4} and {AND,0xF0,0x3C}. Start with len=3, hold iss_ready=1, and have the bench model return results after 3 cycles. Required response: three transfers on consecutive cycles; done pulses once; res_buf reads 8, 5, 0x30; err=0.
- Backpressure: set MAX_INFLIGHT=4 and len=6, and delay all results by 10 cycles. Required response: exactly 4 transfers, then iss_valid stays low until the first result; inflight never exceeds 4.
- Stall stability: hold iss_ready=0 for 5 cycles with iss_valid=1. Required response: iss_op, iss_a and iss_b stay unchanged and no transfer is counted.
- Simultaneous transfer and result at inflight=2. Required response: inflight stays 2; both issue_ptr and res_ptr advance.
- Boundaries:
  - len=0: done pulses 1 cycle after start, with no iss_valid.
  - len=DEPTH: all 8 results are stored.
  - Spurious res_valid in IDLE: err=1 until the next start.
- Assert reset low mid-ISSUE. Required response: busy=0, iss_valid=0, no done pulse, and the buffers read 0. A fresh start then completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer and in-order result collector for the pipelined ALU.
// Replays a loaded {op, a, b} program under a credit limit and stores the returning results.
module alu_issue_ctrl #(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int OP_W         = 3,
  parameter int DATA_W       = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [AW-1:0]            load_addr,
  input  logic [OP_W+2*DATA_W-1:0] load_data,
  input  logic                     start,
  input  logic [AW:0]              len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [DATA_W-1:0]        iss_a,
  output logic [DATA_W-1:0]        iss_b,
  input  logic                     res_valid,
  input  logic [DATA_W-1:0]        res_data,
  input  logic [AW-1:0]            rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int IW = OP_W + 2*DATA_W;
  localparam int CW = 4;
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CRD_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_C   = MAX_INFLIGHT[CW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       n_q, n_d, iptr_q, iptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic              err_q, err_d, busy_q, busy_d, done_q, done_d, vld_q, vld_d;
  logic [IW-1:0]     ins_q, ins_d;
  logic [IW-1:0]     prog_q [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic              prog_we_s, res_we_s, xfer_s, rsp_ok_s;

  assign xfer_s   = vld_q && iss_ready;
  assign rsp_ok_s = res_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && (infl_q != {CW{1'b0}});

  // Next-state, pointer, credit and registered-output logic.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    iptr_d    = iptr_q;
    rptr_d    = rptr_q;
    infl_d    = infl_q;
    err_d     = err_q;
    ins_d     = ins_q;
    prog_we_s = 1'b0;
    res_we_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        prog_we_s = load_en;
        if (start) begin
          n_d    = len;
          iptr_d = {(AW+1){1'b0}};
          rptr_d = {(AW+1){1'b0}};
          infl_d = {CW{1'b0}};
          err_d  = 1'b0;
          if (len == {(AW+1){1'b0}}) begin
            state_d = S_DONE;
          end else if (len > DEPTH_C) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (xfer_s) begin
          iptr_d  = iptr_q + PTR_ONE;
          state_d = (iptr_d == n_q) ? S_DRAIN : S_ISSUE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: state_d = (rptr_q == n_q) ? S_DONE : S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A result with no credit outstanding, or outside a run, is dropped and flagged.
    if (rsp_ok_s) begin
      res_we_s = 1'b1;
      rptr_d   = rptr_q + PTR_ONE;
    end else if (res_valid) begin
      err_d = 1'b1;
    end else begin
      res_we_s = 1'b0;
    end

    case ({xfer_s, rsp_ok_s})
      2'b10:   infl_d = infl_q + CRD_ONE;
      2'b01:   infl_d = infl_q - CRD_ONE;
      default: infl_d = infl_d;
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    vld_d  = (state_d == S_ISSUE) && (infl_d < MAX_C) && (iptr_d < n_d);
    if (state_d == S_ISSUE) begin
      ins_d = prog_q[iptr_d[AW-1:0]];
    end else begin
      ins_d = ins_q;
    end
  end

  // State, counters, buffers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= {(AW+1){1'b0}};
      iptr_q  <= {(AW+1){1'b0}};
      rptr_q  <= {(AW+1){1'b0}};
      infl_q  <= {CW{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      ins_q   <= {IW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        prog_q[i] <= {IW{1'b0}};
        res_q[i]  <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      iptr_q  <= iptr_d;
      rptr_q  <= rptr_d;
      infl_q  <= infl_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      ins_q   <= ins_d;
      if (prog_we_s) prog_q[load_addr] <= load_data;
      if (res_we_s)  res_q[rptr_q[AW-1:0]] <= res_data;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign iss_valid = vld_q;
  assign iss_op    = ins_q[IW-1 -: OP_W];
  assign iss_a     = ins_q[2*DATA_W-1 -: DATA_W];
  assign iss_b     = ins_q[DATA_W-1:0];
  assign rd_data   = res_q[rd_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a transaction-level model checks every cycle,
// a bench-side ALU returns results after a programmable latency.
module tb_alu_issue_ctrl;
  localparam int DEPTH = 8, AW = 3, OP_W = 3, DATA_W = 8, MAXI = 4, IW = 19;

  logic clk = 1'b0;
  logic reset, load_en, start, iss_ready, res_valid;
  logic [AW-1:0] load_addr, rd_addr;
  logic [IW-1:0] load_data;
  logic [AW:0] len;
  logic busy, done, err, iss_valid;
  logic [OP_W-1:0] iss_op;
  logic [DATA_W-1:0] iss_a, iss_b, res_data, rd_data;

  alu_issue_ctrl #(.DEPTH(DEPTH), .AW(AW), .OP_W(OP_W), .DATA_W(DATA_W), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .len(len), .busy(busy), .done(done), .err(err),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b),
    .res_valid(res_valid), .res_data(res_data), .rd_addr(rd_addr), .rd_data(rd_data));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return a;
    endcase
  endfunction

  // ---------------- transaction model ----------------
  logic [IW-1:0] prog_m [DEPTH];
  logic [7:0]    res_m  [DEPTH];
  int  m_n, m_iss, m_ret;
  bit  m_busy, m_done, m_err;
  int  ecount, start_ec, done_lat, first_xfer_ec, last_xfer_ec, xfer_before_ret, max_out, sim2_cnt;
  bit  prev_stall;
  logic [IW-1:0] prev_ins;

  initial begin
    forever begin
      int outstanding;
      bit n_busy, n_done, n_err, exp_v;
      @(negedge clk);
      ecount++;
      if (!reset) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", iss_valid, 0);
        chk("rst_err", err, 0);
        for (int i = 0; i < DEPTH; i++) begin prog_m[i] = '0; res_m[i] = '0; end
        m_n = 0; m_iss = 0; m_ret = 0; m_busy = 0; m_done = 0; m_err = 0; prev_stall = 0;
      end else begin
        outstanding = m_iss - m_ret;
        exp_v = m_busy && (m_iss < m_n) && (outstanding < MAXI);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("iss_valid", iss_valid, exp_v);
        chk("rd_data", rd_data, res_m[rd_addr]);
        if (iss_valid && m_iss < DEPTH) chk("iss_fields", {iss_op, iss_a, iss_b}, prog_m[m_iss]);
        if (prev_stall) chk("stall_hold", {iss_valid, iss_op, iss_a, iss_b}, {1'b1, prev_ins});
        if (done) done_lat = ecount - start_ec;

        prev_stall = iss_valid && !iss_ready;
        prev_ins   = {iss_op, iss_a, iss_b};
        n_busy = m_busy; n_done = 1'b0; n_err = m_err;
        if (!m_busy && !m_done) begin
          if (load_en) prog_m[load_addr] = load_data;
          if (start) begin
            start_ec = ecount; m_n = int'(len); m_iss = 0; m_ret = 0;
            n_err  = (len > DEPTH);
            n_done = (len == 0) || (len > DEPTH);
            n_busy = !n_done;
            first_xfer_ec = -1; xfer_before_ret = 0; max_out = 0; sim2_cnt = 0;
          end
        end else if (m_busy && m_ret == m_n) begin
          n_busy = 1'b0; n_done = 1'b1;
        end
        if (iss_valid && iss_ready) begin
          if (outstanding == 2 && res_valid) sim2_cnt++;
          if (first_xfer_ec < 0) first_xfer_ec = ecount;
          last_xfer_ec = ecount;
          if (m_ret == 0) xfer_before_ret++;
          m_iss++;
        end
        if (res_valid) begin
          if (m_busy && outstanding > 0 && m_ret < DEPTH) begin
            res_m[m_ret] = res_data; m_ret++;
          end else n_err = 1'b1;
        end
        m_busy = n_busy; m_done = n_done; m_err = n_err;
        if (m_iss - m_ret > max_out) max_out = m_iss - m_ret;
        chk("credit_bound", (m_iss - m_ret) <= MAXI, 1);
      end
    end
  end

  // ---------------- bench-side ALU ----------------
  typedef struct packed { logic [7:0] d; int due; } rsp_t;
  rsp_t aq[$];
  int acnt = 0;
  int lat = 1;
  bit spur_req = 1'b0;

  initial begin
    res_valid = 1'b0; res_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) aq.delete();
      else if (iss_valid && iss_ready) aq.push_back('{d: alu(iss_op, iss_a, iss_b), due: acnt + 1 + lat});
      @(posedge clk); acnt++; #1;
      if (spur_req) begin
        res_valid = 1'b1; res_data = 8'hAA; spur_req = 1'b0;
      end else if (aq.size() > 0 && aq[0].due <= acnt + 1) begin
        res_valid = 1'b1; res_data = aq[0].d; void'(aq.pop_front());
      end else begin
        res_valid = 1'b0; res_data = '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic load(input int addr, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    load_en = 1'b1; load_addr = addr[AW-1:0]; load_data = {op, a, b};
    tick();
    load_en = 1'b0;
  endtask

  task automatic go(input int n, input int latency);
    lat = latency; len = n[AW:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 300) chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic rd_chk(input int addr, input logic [7:0] exp, input string name);
    rd_addr = addr[AW-1:0];
    @(negedge clk);
    chk(name, rd_data, exp);
    tick();
  endtask

  initial begin
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; len = '0;
    iss_ready = 1'b1; rd_addr = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    rd_chk(0, 8'h00, "rst_rd0");

    // Basic three-instruction program, ALU latency 3.
    load(0, 3'd0, 8'd5, 8'd3);
    load(1, 3'd1, 8'd9, 8'd4);
    load(2, 3'd2, 8'hF0, 8'h3C);
    go(3, 3); wait_done();
    rd_chk(0, 8'd8, "t1_res0");
    rd_chk(1, 8'd5, "t1_res1");
    rd_chk(2, 8'h30, "t1_res2");
    chk("t1_err", err, 0);
    chk("t1_consecutive", last_xfer_ec - first_xfer_ec, 2);

    // Credit backpressure: 6 ops, ALU latency 10.
    for (int i = 0; i < 6; i++) load(i, 3'(i % 5), 8'(16 * i + 7), 8'(i + 3));
    go(6, 10); wait_done();
    chk("bp_xfer_before_ret", xfer_before_ret, 4);
    chk("bp_max_inflight", max_out, 4);
    rd_chk(5, alu(3'd0, 8'd87, 8'd8), "bp_res5");

    // Stall: ready low for 5 cycles while valid.
    iss_ready = 1'b0;
    go(2, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", iss_valid, 1);
      tick();
    end
    iss_ready = 1'b1;
    wait_done();
    rd_chk(1, alu(3'd1, 8'd23, 8'd4), "stall_res1");

    // Transfer and result coinciding at two in flight.
    go(5, 2); wait_done();
    chk("simul_seen", sim2_cnt >= 1, 1);

    // len = 0.
    go(0, 1); wait_done();
    chk("len0_latency", done_lat, 1);

    // len = DEPTH, 1-cycle ALU: minimum latency.
    for (int i = 0; i < DEPTH; i++) load(i, 3'd4, 8'(i * 3), 8'h55);
    go(DEPTH, 1); wait_done();
    chk("full_latency", done_lat, DEPTH + 3);
    rd_chk(7, 8'(21) ^ 8'h55, "full_res7");

    // Spurious result in IDLE sets err until next start.
    spur_req = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("spur_err", err, 1);
    tick();
    go(1, 1); wait_done();
    chk("spur_cleared", err, 0);

    // len > DEPTH.
    go(9, 1); wait_done();
    chk("len9_err", err, 1);

    // Reset mid-run.
    go(6, 4);
    tick(); tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_valid", iss_valid, 0);
    chk("mr_rd0", rd_data, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    load(0, 3'd3, 8'h0F, 8'hA0);
    load(1, 3'd0, 8'd200, 8'd100);
    go(2, 1); wait_done();
    rd_chk(0, 8'hAF, "mr_res0");
    rd_chk(1, 8'd44, "mr_res1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
